mode_select_encoder: RTL and testbench
======================================

Name: mode_select_encoder

Overview:
- Front-end producer of the one-hot piano mode request consumed by the mode FSM: 001 free, 010 auto-play, 100 learning.
- Takes three raw, bouncy push-buttons, synchronises and debounces each, and edge-detects presses.
- Holds a registered one-hot mode word driven continuously to the FSM's mode input; a `mode_chg` strobe marks each update.
- Guarantees the FSM never sees 000 or a multi-hot code after reset.

Parameters:
- DEBOUNCE_CYCLES, 20'd1000000, consecutive stable cycles required before a debounced level changes; legal range ≥ 2.
- RESET_MODE, 3'b001, mode word loaded at reset; must be one-hot.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn_free  input  1  raw button, high = pressed, asynchronous to clk
- btn_auto  input  1  raw button, high = pressed
- btn_learn  input  1  raw button, high = pressed
- mode_out  output  3  registered one-hot mode request: {learn, auto, free}
- mode_chg  output  1  one-cycle pulse, coincident with the cycle `mode_out` takes a new value
- btn_db  output  3  debounced button levels {learn, auto, free}, for LEDs and debug
- lock  input  1  present only with MODE_SEL_LOCK_EN; high = ignore presses

Behaviour:
- Reset is synchronous (sampled on posedge clk while rst = 1). All of the following clear or load on that edge:
  - `mode_out` = RESET_MODE
  - `mode_chg` = 0
  - `btn_db` = 000
  - sync flops = 0
  - debounce counters = 0
  - edge-detect history = 0
- Reset asserted mid-debounce or mid-update discards the partial count. No press is remembered across reset.
- Per button, the pipeline is a 2-flop synchroniser (s1, s2), then a debouncer:
  - The counter increments while s2 != `btn_db[i]`.
  - The counter clears to 0 on any cycle where s2 == `btn_db[i]` (bounce restarts the count).
  - When the counter would reach DEBOUNCE_CYCLES, `btn_db[i]` toggles and the counter clears.
  - Counter width = $clog2(DEBOUNCE_CYCLES+1). The counter never wraps.
- Press event: `press[i]` = `btn_db[i]` & ~`btn_db_d[i]`, where `btn_db_d` is `btn_db` delayed one cycle. It is combinational and lasts one cycle.
- Release events are ignored. Holding a button produces exactly one press.
- Mode update, on the posedge following a press cycle:
  - Exactly one `press` bit set and the resulting one-hot differs from `mode_out`: `mode_out` ← that one-hot, `mode_chg` ← 1.
  - Exactly one `press` bit set and it equals the current mode: `mode_out` unchanged, `mode_chg` = 0 (no redundant strobe).
  - Two or three `press` bits set in the same cycle: ignored; `mode_out` unchanged, `mode_chg` = 0.
  - No press: hold; `mode_chg` = 0.
- Latency: raw input first sampled high at edge 1 (stable thereafter):
  - `btn_db` rises at edge DEBOUNCE_CYCLES+2.
  - `mode_out` and `mode_chg` update at edge DEBOUNCE_CYCLES+3.
  - Fixed; no variation.
- Invariant: `mode_out` is always exactly one-hot (popcount = 1) from the first post-reset cycle onward. Output is registered, no glitches.
- Presses on different buttons separated by ≥ 1 cycle in their debounced edges are each honoured in order. The last one wins.

Optional Feature:
- MODE_SEL_LOCK_EN defined:
  - The `lock` input port exists.
  - While `lock` = 1 in a press cycle, that press is discarded: `mode_out` holds, `mode_chg` = 0. Debounce continues normally.
  - A button still held when `lock` falls does not generate a late press.
  - Used to freeze mode during auto-play/learning sequences.
- MODE_SEL_LOCK_EN undefined:
  - No `lock` port; all presses are honoured per the rules above.

Test Plan (DEBOUNCE_CYCLES = 4, so L = 7):
- Reset: rst high 2 cycles, buttons low -> `mode_out` = 001, `mode_chg` = 0, `btn_db` = 000, and all stay there for 50 idle cycles.
- Clean press: `btn_auto` high from edge 1 -> `btn_db` = 010 at edge 6; `mode_out` = 010 with a single-cycle `mode_chg` at edge 7. Holding 100 cycles gives no further `mode_chg`.
- Bounce rejection: `btn_learn` toggled high 3 cycles/low 1 cycle ×5, then high stable -> no change until 4 stable cycles elapse; exactly one `mode_chg`; final `mode_out` = 100.
- Same-mode and simultaneous presses:
  - Press `btn_free` while `mode_out` = 001 -> no `mode_chg`.
  - Raise `btn_auto` and `btn_learn` on the same edge -> `mode_out` unchanged, no `mode_chg`.
- Reset mid-debounce: `btn_auto` high, rst pulsed at cycle 3 and released -> counting restarts. `mode_out` = 001 until 4 stable debounce cycles after sync. Then `mode_out` = 010.
- Lock (MODE_SEL_LOCK_EN): `lock` = 1, press `btn_learn` -> `mode_out` unchanged. Drop `lock` while still held -> no change. Release, press again -> `mode_out` = 100.

Source files
------------

// File: rtl/mode_select_encoder.sv
// Debounces three push-buttons and holds a registered one-hot mode request {learn, auto, free}.
// Optional feature MODE_SEL_LOCK_EN adds a `lock` input that discards presses while high.
module mode_select_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [2:0]  RESET_MODE      = 3'b001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_free,
  input  logic       btn_auto,
  input  logic       btn_learn,
`ifdef MODE_SEL_LOCK_EN
  input  logic       lock,
`endif
  output logic [2:0] mode_out,
  output logic       mode_chg,
  output logic [2:0] btn_db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       raw;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       db_q;
  logic [2:0]       db_d;
  logic [2:0]       db_dly_q;
  logic [2:0]       press;
  logic [2:0]       press_ok;
  logic [2:0]       mode_q;
  logic [2:0]       mode_d;
  logic             chg_q;
  logic             chg_d;

  assign raw = {btn_learn, btn_auto, btn_free};

  // Counter runs only while the synchronised level disagrees with the debounced one;
  // any agreeing cycle restarts it, so a bounce never accumulates toward a toggle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      db_d[i]  = db_q[i];
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = db_q & ~db_dly_q;

`ifdef MODE_SEL_LOCK_EN
  assign press_ok = press & {3{~lock}};
`else
  assign press_ok = press;
`endif

  always_comb begin
    mode_d = mode_q;
    chg_d  = 1'b0;
    if ($onehot(press_ok) && (press_ok != mode_q)) begin
      mode_d = press_ok;
      chg_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      mode_q   <= RESET_MODE;
      chg_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      mode_q   <= mode_d;
      chg_q    <= chg_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign mode_out = mode_q;
  assign mode_chg = chg_q;
  assign btn_db   = db_q;

endmodule

// File: tb/tb_mode_select_encoder.sv
// Directed and randomized checks of mode_select_encoder with DEBOUNCE_CYCLES = 4.
module tb_mode_select_encoder;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bf = 1'b0, ba = 1'b0, bl = 1'b0;
`ifdef MODE_SEL_LOCK_EN
  logic       lock = 1'b0;
`endif
  logic [2:0] mode_out;
  logic       mode_chg;
  logic [2:0] btn_db;

  int tests = 0;
  int fails = 0;
  int chg_seen = 0;

  // Reference state: raw samples and s2 values seen since the last reset.
  bit         raw_q [3][$];
  bit         s2_hist [3][$];
  logic [2:0] m_db, m_mode, m_press;
  logic       m_chg;

  always #5 clk = ~clk;

  mode_select_encoder #(.DEBOUNCE_CYCLES(D), .RESET_MODE(3'b001)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_free (bf),
    .btn_auto (ba),
    .btn_learn(bl),
`ifdef MODE_SEL_LOCK_EN
    .lock     (lock),
`endif
    .mode_out (mode_out),
    .mode_chg (mode_chg),
    .btn_db   (btn_db)
  );

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A debounced level flips once the last D synchronised samples all disagree with it;
  // a press is a debounced rise, acted on one edge later if it is a single new mode.
  task automatic model_edge(input logic r, input logic [2:0] raw, input logic lk);
    logic [2:0] db_prev;
    logic [2:0] p;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        raw_q[i].delete();
        s2_hist[i].delete();
      end
      m_db = 3'b000; m_mode = 3'b001; m_chg = 1'b0; m_press = 3'b000;
      return;
    end
    p = m_press & ~{3{lk}};
    m_chg = 1'b0;
    if ($countones(p) == 1 && p != m_mode) begin
      m_mode = p;
      m_chg  = 1'b1;
    end
    db_prev = m_db;
    for (int i = 0; i < 3; i++) begin
      bit s2;
      bit all_diff;
      s2 = (raw_q[i].size() >= 2) ? raw_q[i][raw_q[i].size() - 2] : 1'b0;
      raw_q[i].push_back(raw[i]);
      s2_hist[i].push_back(s2);
      all_diff = (s2_hist[i].size() >= D);
      for (int k = 0; k < D; k++) begin
        if (all_diff && s2_hist[i][s2_hist[i].size() - 1 - k] == m_db[i]) all_diff = 1'b0;
      end
      if (all_diff) m_db[i] = ~m_db[i];
      while (raw_q[i].size() > 8) void'(raw_q[i].pop_front());
      while (s2_hist[i].size() > 8) void'(s2_hist[i].pop_front());
    end
    m_press = m_db & ~db_prev;
  endtask

  task automatic tick();
    logic lk;
    lk = 1'b0;
`ifdef MODE_SEL_LOCK_EN
    lk = lock;
`endif
    model_edge(rst, {bl, ba, bf}, lk);
    @(posedge clk);
    #1;
    chk("mode_out", mode_out, m_mode);
    chk("mode_chg", {2'b00, mode_chg}, {2'b00, m_chg});
    chk("btn_db", btn_db, m_db);
    chk_int("onehot", $countones(mode_out), 1);
    if (mode_chg) chg_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    chk("reset_mode", mode_out, 3'b001);
    chk("reset_db", btn_db, 3'b000);
    chg_seen = 0;
    ticks(50);
    chk_int("idle_chg", chg_seen, 0);
    chk("idle_mode", mode_out, 3'b001);

    // Clean press on auto: db at edge 6, mode/strobe at edge 7
    ba = 1'b1;
    ticks(5);
    chk("clean_db_e5", btn_db, 3'b000);
    tick();
    chk("clean_db_e6", btn_db, 3'b010);
    chk("clean_mode_e6", mode_out, 3'b001);
    tick();
    chk("clean_mode_e7", mode_out, 3'b010);
    chk("clean_chg_e7", {2'b00, mode_chg}, 3'b001);
    chg_seen = 0;
    ticks(100);
    chk_int("hold_no_chg", chg_seen, 0);
    ba = 1'b0;
    ticks(10);

    // Bounce rejection on learn
    chg_seen = 0;
    for (int r = 0; r < 5; r++) begin
      bl = 1'b1; ticks(3);
      bl = 1'b0; ticks(1);
    end
    chk("bounce_mode_mid", mode_out, 3'b010);
    bl = 1'b1;
    ticks(12);
    chk_int("bounce_chg_count", chg_seen, 1);
    chk("bounce_mode", mode_out, 3'b100);
    bl = 1'b0;
    ticks(10);

    // Back to free, then a redundant free press
    bf = 1'b1; ticks(10);
    chk("free_mode", mode_out, 3'b001);
    bf = 1'b0; ticks(10);
    chg_seen = 0;
    bf = 1'b1; ticks(10);
    chk_int("same_mode_chg", chg_seen, 0);
    bf = 1'b0; ticks(10);

    // Simultaneous auto + learn
    chg_seen = 0;
    ba = 1'b1; bl = 1'b1;
    ticks(12);
    chk_int("simul_chg", chg_seen, 0);
    chk("simul_mode", mode_out, 3'b001);
    ba = 1'b0; bl = 1'b0;
    ticks(10);

    // Reset mid-debounce: rst at cycle 3 restarts the pipeline
    ba = 1'b1;
    ticks(2);
    rst = 1'b1; tick(); rst = 1'b0;
    ticks(6);
    chk("rst_mid_mode_before", mode_out, 3'b001);
    tick();
    chk("rst_mid_mode_after", mode_out, 3'b010);
    ba = 1'b0;
    ticks(10);

`ifdef MODE_SEL_LOCK_EN
    lock = 1'b1;
    bl = 1'b1; ticks(12);
    chk("lock_hold", mode_out, 3'b010);
    lock = 1'b0; ticks(10);
    chk("lock_no_late", mode_out, 3'b010);
    bl = 1'b0; ticks(10);
    bl = 1'b1; ticks(12);
    chk("lock_release", mode_out, 3'b100);
    bl = 1'b0; ticks(10);
`endif

    // Randomized button activity against the reference model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) bf = ~bf;
      if ($urandom_range(0, 5) == 0) ba = ~ba;
      if ($urandom_range(0, 5) == 0) bl = ~bl;
`ifdef MODE_SEL_LOCK_EN
      if ($urandom_range(0, 15) == 0) lock = ~lock;
`endif
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
